normalize_round_stage: RTL and testbench

Pipelined normalizer at the back end of the MAC datapath: takes the two's-complement accumulated sum of aligned partial products together with the shared max exponent, and returns a rounded sign/exponent/mantissa result. It converts back from the fixed-point, max-exponent-aligned domain that the alignment stage produces: absolute value, leading-one detect, left shift, exponent re-bias, and round-to-nearest-even. It has three register stages and uses a valid/ready handshake on both sides. The `Q_frac` sideband is carried along with each result.

---
 rtl/normalize_round_stage_pkg.sv | 36 +++
 rtl/normalize_round_stage_lod_shift.sv | 38 +++
 rtl/normalize_round_stage.sv | 169 ++++++++++++++++
 tb/tb_normalize_round_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/normalize_round_stage_pkg.sv
// Shared widths, limits, result type and cell cost model for the MAC back-end normalizer.
package normalize_round_stage_pkg;

    localparam int NRS_SUM_W  = 19;
    localparam int NRS_FRAC_W = 13;
    localparam int NRS_MAN_W  = 4;
    localparam int NRS_EXP_W  = 6;
    localparam int NRS_QF_W   = 5;
    localparam int NRS_COST_W = 51;

    localparam logic [NRS_EXP_W-1:0] EXP_MAX = 6'd63;

    // Relative cost of each primitive cell type used by the leading-one/shift block.
    localparam int CELL_COST_MX   = 3;
    localparam int CELL_COST_COM6 = 8;
    localparam int CELL_COST_OR2  = 1;

    typedef struct packed {
        logic                 sign;
        logic [NRS_EXP_W-1:0] exp;
        logic [NRS_MAN_W-1:0] man;
    } nrs_result_t;

    // Cell inventory of lod_shift: a log shifter of p_w levels of 2:1 muxes, one COM6
    // leading-one cell per 6-bit group, group select muxes and an OR2 any-one tree.
    function automatic int lod_shift_cost(input int sum_w, input int p_w);
        int groups;
        int n_mx;
        int n_or2;
        groups = (sum_w + 5) / 6;
        n_mx   = p_w * sum_w + (groups - 1) * p_w;
        n_or2  = sum_w - 1;
        return n_mx * CELL_COST_MX + groups * CELL_COST_COM6 + n_or2 * CELL_COST_OR2;
    endfunction

endpackage

// File: rtl/normalize_round_stage_lod_shift.sv
// Leading-one detector plus left shifter: moves the leading one of mag_i to the MSB.
module lod_shift
    import normalize_round_stage_pkg::*;
#(
    parameter int SUM_W = NRS_SUM_W,
    parameter int P_W   = $clog2(SUM_W)
) (
    input  logic [SUM_W-1:0]      mag_i,
    output logic [P_W-1:0]        p_o,
    output logic [SUM_W-1:0]      shifted_o,
    output logic                  zero_o,
    output logic [NRS_COST_W-1:0] cost_o
);

    logic [P_W-1:0]   amt;
    logic [SUM_W-1:0] lvl [0:P_W];

    // Priority scan: the highest set bit wins, p stays 0 for an all-zero magnitude.
    always_comb begin
        p_o = '0;
        for (int i = 0; i < SUM_W; i++) begin
            if (mag_i[i]) p_o = P_W'(i);
        end
    end

    assign amt    = P_W'(SUM_W - 1) - p_o;
    assign lvl[0] = mag_i;

    for (genvar k = 0; k < P_W; k++) begin : g_shift
        assign lvl[k+1] = amt[k] ? (lvl[k] << (1 << k)) : lvl[k];
    end

    assign shifted_o = lvl[P_W];
    // After normalisation the MSB is set for every nonzero magnitude.
    assign zero_o    = ~lvl[P_W][SUM_W-1];
    assign cost_o    = NRS_COST_W'(lod_shift_cost(SUM_W, P_W));

endmodule

// File: rtl/normalize_round_stage.sv
// Three-stage normalize/round back end: abs value, normalize, round-to-nearest-even and pack.
module normalize_round_stage
    import normalize_round_stage_pkg::*;
#(
    parameter int SUM_W  = NRS_SUM_W,
    parameter int FRAC_W = NRS_FRAC_W,
    parameter int MAN_W  = NRS_MAN_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic signed [SUM_W-1:0] i_sum,
    input  logic [NRS_EXP_W-1:0]    i_max_exp,
    input  logic [NRS_QF_W-1:0]     i_Q_frac,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_sign,
    output logic [NRS_EXP_W-1:0]    o_exp,
    output logic [MAN_W-1:0]        o_man,
    output logic [NRS_QF_W-1:0]     o_Q_frac,
    output logic [NRS_COST_W-1:0]   number
);

    localparam int P_W = $clog2(SUM_W);

    // Mantissa/guard/sticky slice of the normalized value, then carry-out, flush and saturate.
    function automatic nrs_result_t round_pack(input logic sign, input logic zero,
                                               input logic signed [7:0] e,
                                               input logic [MAN_W-1:0] man,
                                               input logic guard, input logic sticky);
        logic [MAN_W:0]    man_r;
        logic signed [7:0] e_r;
        nrs_result_t       r;
        man_r = {1'b0, man};
        e_r   = e;
        if (guard & (sticky | man[0])) man_r = man_r + 1'b1;
        if (man_r[MAN_W]) begin
            man_r = '0;
            e_r   = e_r + 8'sd1;
        end
        r = '0;
        if (zero || e_r <= 8'sd0) begin
            r = '0;
        end else if (e_r > $signed({2'b00, EXP_MAX})) begin
            r.sign = sign;
            r.exp  = EXP_MAX;
            r.man  = '1;
        end else begin
            r.sign = sign;
            r.exp  = e_r[NRS_EXP_W-1:0];
            r.man  = man_r[MAN_W-1:0];
        end
        return r;
    endfunction

    logic en;

    logic                 vld_p1_q, sign_p1_q, sign_p1_d;
    logic [SUM_W-1:0]     mag_p1_q, mag_p1_d;
    logic [NRS_EXP_W-1:0] exp_p1_q;
    logic [NRS_QF_W-1:0]  qf_p1_q;

    logic [P_W-1:0]       lod_p;
    logic [SUM_W-1:0]     lod_shifted;
    logic                 lod_zero;

    logic                 vld_p2_q, sign_p2_q, zero_p2_q, guard_p2_q, sticky_p2_q;
    logic                 guard_p2_d, sticky_p2_d;
    logic signed [7:0]    e_p2_q, e_p2_d;
    logic [MAN_W-1:0]     man_p2_q, man_p2_d;
    logic [NRS_QF_W-1:0]  qf_p2_q;

    logic                 vld_p3_q;
    nrs_result_t          res_p3_q, res_p3_d;
    logic [NRS_QF_W-1:0]  qf_p3_q;

    // The whole pipe advances as one unit; it only freezes while a result waits for downstream.
    assign en      = ~vld_p3_q | i_ready;
    assign o_ready = en;

    // ---- stage 1: sign and magnitude ----
    always_comb begin
        sign_p1_d = i_sum[SUM_W-1];
        mag_p1_d  = sign_p1_d ? SUM_W'(-i_sum) : SUM_W'(i_sum);
    end

    // Stage 1 register: magnitude plus the exponent and sideband it travels with.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1_q  <= 1'b0;
            sign_p1_q <= 1'b0;
            mag_p1_q  <= '0;
            exp_p1_q  <= '0;
            qf_p1_q   <= '0;
        end else if (en) begin
            vld_p1_q  <= i_valid;
            sign_p1_q <= sign_p1_d;
            mag_p1_q  <= mag_p1_d;
            exp_p1_q  <= i_max_exp;
            qf_p1_q   <= i_Q_frac;
        end
    end

    // ---- stage 2: normalize ----
    lod_shift #(.SUM_W(SUM_W), .P_W(P_W)) u_lod_shift (
        .mag_i     (mag_p1_q),
        .p_o       (lod_p),
        .shifted_o (lod_shifted),
        .zero_o    (lod_zero),
        .cost_o    (number)
    );

    // Split the normalized magnitude into mantissa, guard and sticky; re-bias the exponent.
    always_comb begin
        man_p2_d    = lod_shifted[SUM_W-2 -: MAN_W];
        guard_p2_d  = lod_shifted[SUM_W-2-MAN_W];
        sticky_p2_d = |lod_shifted[SUM_W-3-MAN_W:0];
        e_p2_d      = $signed(8'(exp_p1_q) + 8'(lod_p) - 8'(FRAC_W));
    end

    // Stage 2 register: unrounded fields ready for rounding.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p2_q    <= 1'b0;
            sign_p2_q   <= 1'b0;
            zero_p2_q   <= 1'b0;
            e_p2_q      <= '0;
            man_p2_q    <= '0;
            guard_p2_q  <= 1'b0;
            sticky_p2_q <= 1'b0;
            qf_p2_q     <= '0;
        end else if (en) begin
            vld_p2_q    <= vld_p1_q;
            sign_p2_q   <= sign_p1_q;
            zero_p2_q   <= lod_zero;
            e_p2_q      <= e_p2_d;
            man_p2_q    <= man_p2_d;
            guard_p2_q  <= guard_p2_d;
            sticky_p2_q <= sticky_p2_d;
            qf_p2_q     <= qf_p1_q;
        end
    end

    // ---- stage 3: round and pack ----
    always_comb begin
        res_p3_d = round_pack(sign_p2_q, zero_p2_q, e_p2_q, man_p2_q, guard_p2_q, sticky_p2_q);
    end

    // Output register: packed result held until downstream takes it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p3_q <= 1'b0;
            res_p3_q <= '0;
            qf_p3_q  <= '0;
        end else if (en) begin
            vld_p3_q <= vld_p2_q;
            res_p3_q <= res_p3_d;
            qf_p3_q  <= qf_p2_q;
        end
    end

    assign o_valid  = vld_p3_q;
    assign o_sign   = res_p3_q.sign;
    assign o_exp    = res_p3_q.exp;
    assign o_man    = res_p3_q.man;
    assign o_Q_frac = qf_p3_q;

endmodule

// File: tb/tb_normalize_round_stage.sv
// Directed bench for normalize_round_stage: values, rounding, range limits, stall and reset.
module tb_normalize_round_stage;

    logic        clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [18:0] i_sum;
    logic [5:0]  i_max_exp;
    logic [4:0]  i_Q_frac;
    logic        o_valid;
    logic        i_ready;
    logic        o_sign;
    logic [5:0]  o_exp;
    logic [3:0]  o_man;
    logic [4:0]  o_Q_frac;
    logic [50:0] number;

    int n_checks = 0;
    int n_fail   = 0;

    normalize_round_stage dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_sum     (i_sum),
        .i_max_exp (i_max_exp),
        .i_Q_frac  (i_Q_frac),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sign    (o_sign),
        .o_exp     (o_exp),
        .o_man     (o_man),
        .o_Q_frac  (o_Q_frac),
        .number    (number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample, then wait (bounded) for its result; lat counts cycles from transfer.
    task automatic run_single(input logic [18:0] s, input logic [5:0] e, input logic [4:0] q,
                              output logic [15:0] res, output int lat);
        @(negedge clk);
        i_ready   = 1'b1;
        i_valid   = 1'b1;
        i_sum     = s;
        i_max_exp = e;
        i_Q_frac  = q;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_sum   = '0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = {o_sign, o_exp, o_man, o_Q_frac};
    endtask

    task automatic test_reset();
        logic [15:0] res;
        int lat;
        i_rst_n = 1'b0; i_valid = 1'b1; i_ready = 1'b0;
        i_sum = 19'h02000; i_max_exp = 6'd20; i_Q_frac = 5'd7;
        repeat (2) @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        n_checks++;
        if ({o_sign, o_exp, o_man, o_Q_frac} !== 16'h0) begin
            n_fail++; $display("FAIL reset_fields: got %h expected 0000", {o_sign, o_exp, o_man, o_Q_frac});
        end
        // Release with a sample already presented: it must transfer on the very next edge.
        i_rst_n = 1'b1; i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = {o_sign, o_exp, o_man, o_Q_frac};
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL first_xfer_latency: got %0d expected 3", lat); end
        n_checks++;
        if (res !== {1'b0, 6'd20, 4'h0, 5'd7}) begin
            n_fail++; $display("FAIL first_xfer_result: got %h expected %h", res, {1'b0, 6'd20, 4'h0, 5'd7});
        end
    endtask

    task automatic test_basic();
        logic [18:0] vs [3];
        logic [5:0]  ve [3];
        logic [15:0] vx [3];
        logic [15:0] res;
        int lat;
        vs[0] = 19'h02000; ve[0] = 6'd20; vx[0] = {1'b0, 6'd20, 4'h0, 5'd1};
        vs[1] = 19'h7E000; ve[1] = 6'd20; vx[1] = {1'b1, 6'd20, 4'h0, 5'd2};
        vs[2] = 19'h40000; ve[2] = 6'd20; vx[2] = {1'b1, 6'd25, 4'h0, 5'd3};
        for (int i = 0; i < 3; i++) begin
            run_single(vs[i], ve[i], 5'(i + 1), res, lat);
            n_checks++;
            if (lat !== 3) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d expected 3", i, lat); end
            n_checks++;
            if (res !== vx[i]) begin n_fail++; $display("FAIL basic_result[%0d]: got %h expected %h", i, res, vx[i]); end
        end
    endtask

    task automatic test_rounding();
        logic [18:0] vs [3];
        logic [15:0] vx [3];
        logic [15:0] res;
        int lat;
        vs[0] = 19'h02100; vx[0] = {1'b0, 6'd20, 4'h0, 5'd4};
        vs[1] = 19'h02300; vx[1] = {1'b0, 6'd20, 4'h2, 5'd5};
        vs[2] = 19'h03F00; vx[2] = {1'b0, 6'd21, 4'h0, 5'd6};
        for (int i = 0; i < 3; i++) begin
            run_single(vs[i], 6'd20, 5'(i + 4), res, lat);
            n_checks++;
            if (res !== vx[i]) begin n_fail++; $display("FAIL round_result[%0d]: got %h expected %h", i, res, vx[i]); end
        end
    endtask

    task automatic test_range();
        logic [15:0] res;
        int lat;
        run_single(19'h20000, 6'd60, 5'd10, res, lat);
        n_checks++;
        if (res !== {1'b0, 6'd63, 4'hF, 5'd10}) begin
            n_fail++; $display("FAIL saturate: got %h expected %h", res, {1'b0, 6'd63, 4'hF, 5'd10});
        end
        run_single(19'h00001, 6'd5, 5'd11, res, lat);
        n_checks++;
        if (res !== {1'b0, 6'd0, 4'h0, 5'd11}) begin
            n_fail++; $display("FAIL flush: got %h expected %h", res, {1'b0, 6'd0, 4'h0, 5'd11});
        end
        run_single(19'h00000, 6'd20, 5'd12, res, lat);
        n_checks++;
        if (res !== {1'b0, 6'd0, 4'h0, 5'd12}) begin
            n_fail++; $display("FAIL zero_in: got %h expected %h", res, {1'b0, 6'd0, 4'h0, 5'd12});
        end
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL zero_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_stall();
        logic [18:0] vs [6];
        logic [5:0]  ve [6];
        logic [15:0] vx [6];
        logic [15:0] got [8];
        logic [15:0] held;
        int sent  = 0;
        int rcvd  = 0;
        int stall = 0;
        bit seen_first = 1'b0;
        vs[0] = 19'h02000; ve[0] = 6'd10; vx[0] = {1'b0, 6'd10, 4'h0, 5'd1};
        vs[1] = 19'h02300; ve[1] = 6'd11; vx[1] = {1'b0, 6'd11, 4'h2, 5'd2};
        vs[2] = 19'h7E000; ve[2] = 6'd12; vx[2] = {1'b1, 6'd12, 4'h0, 5'd3};
        vs[3] = 19'h03000; ve[3] = 6'd13; vx[3] = {1'b0, 6'd13, 4'h8, 5'd4};
        vs[4] = 19'h04000; ve[4] = 6'd14; vx[4] = {1'b0, 6'd15, 4'h0, 5'd5};
        vs[5] = 19'h02800; ve[5] = 6'd15; vx[5] = {1'b0, 6'd15, 4'h4, 5'd6};
        held = '0;
        for (int i = 0; i < 8; i++) got[i] = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (o_valid && !seen_first) begin
                seen_first = 1'b1;
                stall = 4;
                held = {o_sign, o_exp, o_man, o_Q_frac};
            end
            i_ready = (stall == 0);
            if (sent < 6) begin
                i_valid = 1'b1; i_sum = vs[sent]; i_max_exp = ve[sent]; i_Q_frac = 5'(sent + 1);
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (stall > 0) begin
                n_checks++;
                if (o_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 0", cyc, o_ready); end
                if (stall < 4) begin
                    n_checks++;
                    if ({o_valid, o_sign, o_exp, o_man, o_Q_frac} !== {1'b1, held}) begin
                        n_fail++;
                        $display("FAIL stall_hold[%0d]: got %h expected %h", cyc,
                                 {o_valid, o_sign, o_exp, o_man, o_Q_frac}, {1'b1, held});
                    end
                end
                stall--;
            end
            if (o_valid && i_ready) begin
                if (rcvd < 8) got[rcvd] = {o_sign, o_exp, o_man, o_Q_frac};
                rcvd++;
            end
            if (i_valid && o_ready) sent++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        n_checks++;
        if (rcvd !== 6) begin n_fail++; $display("FAIL stall_count: got %0d expected 6", rcvd); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got[i] !== vx[i]) begin n_fail++; $display("FAIL stall_order[%0d]: got %h expected %h", i, got[i], vx[i]); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_ready = 1'b1; i_valid = 1'b1;
            i_sum = 19'h02000; i_max_exp = 6'(30 + i); i_Q_frac = 5'(20 + i);
        end
        @(negedge clk);
        i_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b1) begin n_fail++; $display("FAIL inflight_valid: got %b expected 1", o_valid); end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b expected 0", o_valid); end
        n_checks++;
        if ({o_sign, o_exp, o_man, o_Q_frac} !== 16'h0) begin
            n_fail++; $display("FAIL async_reset_fields: got %h expected 0000", {o_sign, o_exp, o_man, o_Q_frac});
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        run_single(19'h02300, 6'd20, 5'd9, res, lat);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 3", lat); end
        n_checks++;
        if (res !== {1'b0, 6'd20, 4'h2, 5'd9}) begin
            n_fail++; $display("FAIL post_reset_result: got %h expected %h", res, {1'b0, 6'd20, 4'h2, 5'd9});
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_sum = '0; i_max_exp = '0; i_Q_frac = '0;
        test_reset();
        test_basic();
        test_rounding();
        test_range();
        test_stall();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
